// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants, defaults and state encoding
package riscv_pkg;

    localparam int WORDSIZE_DEFAULT         = 64;
    localparam int INSTRUCTION_SIZE_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with load, advance and hold
module program_counter #(
    parameter int                   WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0]  RESET_PC = '0,
    parameter logic [WORDSIZE-1:0]  PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WORDSIZE-1:0] load_value,
    input  logic                advance,
    output logic [WORDSIZE-1:0] pc
);

    // Load wins over advance; neither asserted means hold. Advance wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID register, stall/redirect/halt control
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int                           WORDSIZE         = WORDSIZE_DEFAULT,
    parameter int                           INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEFAULT,
    parameter logic [WORDSIZE-1:0]          RESET_PC         = '0,
    parameter logic [WORDSIZE-1:0]          PC_STEP          = 4,
    parameter logic [INSTRUCTION_SIZE-1:0]  HALT_INSTR       = HALT_INSTR_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [WORDSIZE-1:0]         redirect_target,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    output logic                        id_valid,
    output logic [WORDSIZE-1:0]         id_pc,
    output logic [INSTRUCTION_SIZE-1:0] id_instruction,
    output logic                        halted,
    output logic                        fetch_error
);

    localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(NOP_INSTR);

    fetch_state_t        state, next_state;
    logic [WORDSIZE-1:0] pc;
    logic                pc_load, pc_advance;
    logic                id_capture, id_flush;

    program_counter #(
        .WORDSIZE (WORDSIZE),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_program_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_load),
        .load_value (redirect_target),
        .advance    (pc_advance),
        .pc         (pc)
    );

    assign imem_addr   = pc;
    assign halted      = (state == ST_HALT);
    assign fetch_error = (state == ST_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        id_capture = 1'b0;
        id_flush   = 1'b0;
        case (state)
            ST_RUN: begin
                if (redirect) begin
                    // Redirect beats stall: the wrong-path word in IF/ID must go.
                    id_flush = 1'b1;
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_load = 1'b1;
                    end else begin
                        next_state = ST_ERROR;
                    end
                end else if (!stall) begin
                    id_capture = 1'b1;
                    if (imem_instruction == HALT_INSTR) begin
                        next_state = ST_HALT;
                    end else begin
                        pc_advance = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // The halt word stays in ID while the decoder is stalled on it.
                id_flush = !stall;
            end
            ST_ERROR: begin
                id_flush = 1'b1;
            end
            default: begin
                next_state = ST_ERROR;
                id_flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instruction <= NOP;
        end else if (id_flush) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instruction <= NOP;
        end else if (id_capture) begin
            id_valid       <= 1'b1;
            id_pc          <= pc;
            id_instruction <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench against a behavioural fetch model
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0073;
    localparam logic [63:0] HIGH_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        halted;
    logic        fetch_error;

    logic [63:0] imem_addr2;
    logic        id_valid2;
    logic [63:0] id_pc2;
    logic [31:0] id_instruction2;
    logic        halted2;
    logic        fetch_error2;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    logic [63:0] m_pc;
    logic        m_valid;
    logic [63:0] m_idpc;
    logic [31:0] m_instr;
    logic        m_halt;
    logic        m_err;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_addr[7:2]];

    instruction_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_instruction   (id_instruction),
        .halted           (halted),
        .fetch_error      (fetch_error)
    );

    instruction_fetch #(.RESET_PC(HIGH_PC)) dut_high (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (1'b0),
        .redirect         (1'b0),
        .redirect_target  (64'd0),
        .imem_addr        (imem_addr2),
        .imem_instruction (32'h0000_0093),
        .id_valid         (id_valid2),
        .id_pc            (id_pc2),
        .id_instruction   (id_instruction2),
        .halted           (halted2),
        .fetch_error      (fetch_error2)
    );

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("id_valid", {63'd0, id_valid}, {63'd0, m_valid});
        check_eq("id_instruction", {32'd0, id_instruction}, {32'd0, m_instr});
        if (m_valid) check_eq("id_pc", id_pc, m_idpc);
        check_eq("halted", {63'd0, halted}, {63'd0, m_halt});
        check_eq("fetch_error", {63'd0, fetch_error}, {63'd0, m_err});
    endtask

    function automatic void model_reset();
        m_pc = 64'd0; m_valid = 1'b0; m_idpc = 64'd0; m_instr = NOP;
        m_halt = 1'b0; m_err = 1'b0;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    function automatic void model_edge();
        logic [31:0] word;
        if (m_err) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (m_halt) begin
            if (!stall) begin m_valid = 1'b0; m_instr = NOP; end
        end else if (redirect) begin
            m_valid = 1'b0; m_instr = NOP; m_idpc = 64'd0;
            if (redirect_target % 4 == 0) m_pc = redirect_target;
            else m_err = 1'b1;
        end else if (!stall) begin
            word = mem[(m_pc / 4) % 64];
            m_idpc = m_pc; m_instr = word; m_valid = 1'b1;
            if (word == HALT) m_halt = 1'b1;
            else m_pc = m_pc + 64'd4;
        end
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("reset_id_pc", id_pc, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = NOP;
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = HALT;
        mem[20] = HALT;

        // Reset mid-cycle, then sequential fetch from 0.
        @(posedge clk);
        #3;
        do_reset();
        check_eq("high_reset_addr", imem_addr2, HIGH_PC);
        cycle();
        check_eq("first_instr", {32'd0, id_instruction}, 64'h0050_0093);
        check_eq("high_wrap_addr", imem_addr2, 64'd0);
        check_eq("high_id_pc", id_pc2, HIGH_PC);
        check_eq("high_no_error", {63'd0, fetch_error2}, 64'd0);
        check_eq("high_valid", {63'd0, id_valid2 & ~halted2}, 64'd1);
        cycle();
        check_eq("second_pc", id_pc, 64'd4);

        // Stall two cycles at pc 8, then resume.
        stall = 1'b1;
        cycle();
        cycle();
        check_eq("stall_addr", imem_addr, 64'd8);
        stall = 1'b0;
        cycle();

        // Redirect with simultaneous stall flushes and loads the target.
        stall = 1'b1; redirect = 1'b1; redirect_target = 64'h40;
        cycle();
        check_eq("redir_flush", {32'd0, id_instruction}, 64'h13);
        stall = 1'b0; redirect = 1'b0;
        cycle();
        check_eq("redir_id_pc", id_pc, 64'h40);

        // Halt at 0xC, then ignore a redirect.
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        check_eq("halt_word", {32'd0, id_instruction}, 64'h73);
        check_eq("halt_flag", {63'd0, halted}, 64'd1);
        cycle();
        redirect = 1'b1; redirect_target = 64'd0;
        cycle();
        cycle();
        check_eq("halt_addr", imem_addr, 64'hC);
        redirect = 1'b0;

        // Misaligned redirect locks into the error state until reset.
        do_reset();
        cycle();
        redirect = 1'b1; redirect_target = 64'h42;
        cycle();
        check_eq("err_flag", {63'd0, fetch_error}, 64'd1);
        check_eq("err_pc", imem_addr, 64'd4);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        do_reset();
        check_eq("err_cleared", {63'd0, fetch_error}, 64'd0);

        // Randomized traffic with occasional resets, halts and misaligned targets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_reset();
            end else begin
                stall = ($urandom_range(0, 3) == 0);
                redirect = ($urandom_range(0, 7) == 0);
                redirect_target = {56'd0, 6'($urandom_range(4, 63)), 2'b00};
                if ($urandom_range(0, 15) == 0)
                    redirect_target = redirect_target + 64'($urandom_range(1, 3));
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
